// File: rtl/delay_pipe_ctrl.sv
// Flow-control sequencer for a fixed-latency, non-stallable datapath.
// Credits reserve a return-FIFO slot for every beat launched.
module delay_pipe_ctrl #(
  parameter int WIDTH      = 8,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = LATENCY + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] dp_din,
  input  logic [WIDTH-1:0] dp_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             ovf_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1);

  logic [LATENCY-1:0] r_vld;
  logic [WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_dp_din;
  logic               r_ovf;

  logic          w_fire_in;
  logic          w_fire_out;
  logic          w_wr;
  logic          w_full;
  logic          w_push;
  logic [CW-1:0] w_inflight;
  logic [CW-1:0] w_occ;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) f_inc = '0;
    else                          f_inc = p + PW'(1);
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      w_inflight = w_inflight + CW'(r_vld[i]);
    end
  end

  // in_ready uses only registered state, so no path from out_ready
  assign w_occ      = w_inflight + r_cnt;
  assign in_ready   = rst_n & (w_occ < CW'(FIFO_DEPTH));
  assign w_fire_in  = in_valid & in_ready;
  assign out_valid  = (r_cnt != '0);
  assign w_fire_out = out_valid & out_ready;
  assign w_wr       = r_vld[LATENCY-1];
  assign w_full     = (r_cnt == CW'(FIFO_DEPTH));
  assign w_push     = w_wr & (~w_full | w_fire_out);

  assign dp_din   = r_dp_din;
  assign out_data = r_mem[r_rd_ptr];
  assign busy     = (w_occ != '0);
  assign ovf_err  = r_ovf;

  generate
    if (LATENCY == 1) begin : g_vld1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_vld <= '0;
        else        r_vld <= w_fire_in;
      end
    end else begin : g_vldn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_vld <= '0;
        else        r_vld <= {r_vld[LATENCY-2:0], w_fire_in};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_din <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_dp_din <= w_fire_in ? in_data : '0;
      if (w_wr && w_full && !w_fire_out) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= dp_dout;
        r_wr_ptr        <= f_inc(r_wr_ptr);
      end
      if (w_fire_out) r_rd_ptr <= f_inc(r_rd_ptr);
      unique case ({w_push, w_fire_out})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_pipe_ctrl.sv
// Directed bench for delay_pipe_ctrl with LATENCY=4, FIFO_DEPTH=6.
// A negedge scoreboard checks ordering of every popped beat.
module tb_delay_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] dp_din;
  logic [7:0] dp_dout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       ovf_err;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  delay_pipe_ctrl #(.WIDTH(8), .LATENCY(4), .FIFO_DEPTH(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dp_din(dp_din), .dp_dout(dp_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .ovf_err(ovf_err)
  );

  // datapath: dp_din is its first stage, three more registers follow
  logic [7:0] d1, d2, d3;
  always_ff @(posedge clk) begin
    d1 <= dp_din;
    d2 <= d1;
    d3 <= d2;
  end
  assign dp_dout = d3;

  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) q.delete();
    else begin
      if (in_valid && in_ready) q.push_back(in_data);
      if (out_valid && out_ready) begin
        n_out++;
        total++;
        e = (q.size() != 0) ? q.pop_front() : 8'hxx;
        assert (out_data === e) else begin
          bad++;
          $error("FAIL sb_order got=%0h exp=%0h", out_data, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx, base, cyc, cnt_in;
    logic acc, r0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_dp_din", dp_din, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    tick();

    // single beat
    in_valid = 1'b1; in_data = 8'hA5;
    chk("sb_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; in_data = '0;
    chk("sb_dp_din", dp_din, 8'hA5);
    chk("sb_busy1", busy, 1);
    chk("sb_ov1", out_valid, 0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("sb_ov_wait", out_valid, 0);
      chk("sb_busy_wait", busy, 1);
    end
    tick();
    chk("sb_ov5", out_valid, 1);
    chk("sb_data5", out_data, 8'hA5);
    tick();
    chk("sb_ov6", out_valid, 0);
    chk("sb_busy6", busy, 0);
    chk("sb_dp_din0", dp_din, 0);

    // streaming 32 beats
    base = n_out;
    for (int k = 0; k < 40; k++) begin
      in_valid = (k < 32);
      in_data  = 8'(k);
      if (k < 32) chk("st_in_ready", in_ready, 1);
      chk("st_ov", out_valid, 32'(k >= 5 && k < 37));
      if (k >= 5 && k < 37) chk("st_data", out_data, 32'(k - 5));
      tick();
    end
    in_valid = 1'b0;
    chk("st_count", n_out - base, 32);

    // back-pressure
    out_ready = 1'b0; idx = 0;
    for (int k = 0; k < 12; k++) begin
      in_valid = (idx < 10);
      in_data  = 8'(8'h40 + idx);
      acc = in_valid & in_ready;
      tick();
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 6);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_ov", out_valid, 1);
    chk("bp_head", out_data, 8'h40);
    chk("bp_busy", busy, 1);
    out_ready = 1'b1; base = n_out; cyc = 0;
    while ((idx < 10 || n_out - base < 10) && cyc < 200) begin
      in_valid = (idx < 10);
      in_data  = 8'(8'h40 + idx);
      acc = in_valid & in_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp_drained", n_out - base, 10);
    chk("bp_ovf", ovf_err, 0);
    chk("bp_busy_end", busy, 0);

    // full FIFO then push/pop across pointer wrap
    out_ready = 1'b0; idx = 0; base = n_out;
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h80 + idx);
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    chk("wr_full_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h80 + idx);
      acc = in_ready;
      tick();
      if (acc) idx++;
      chk("wr_busy", busy, 1);
    end
    in_valid = 1'b0; cyc = 0;
    while (n_out - base < idx && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("wr_count", n_out - base, idx);
    chk("wr_ovf", ovf_err, 0);

    // reset with 3 in flight and 2 buffered
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h90 + k);
      chk("rm_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("rm_pre_ov", out_valid, 1);
    chk("rm_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rm_ov", out_valid, 0);
    chk("rm_busy", busy, 0);
    chk("rm_in_ready", in_ready, 0);
    tick(); tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rm_no_stale", out_valid, 0);
    end
    in_valid = 1'b1; in_data = 8'h3C;
    chk("rm_new_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("rm_new_wait", out_valid, 0);
      tick();
    end
    chk("rm_new_ov", out_valid, 1);
    chk("rm_new_data", out_data, 8'h3C);
    tick();

    // random valid/ready, 1000 beats
    base = n_out; cnt_in = 0; cyc = 0;
    while (n_out - base < 1000 && cyc < 20000) begin
      if (!in_valid && cnt_in < 1000 && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        in_data  = 8'(cnt_in);
      end
      out_ready = 1'($urandom_range(0, 1));
      r0 = in_ready;
      out_ready = ~out_ready;
      #1;
      chk("rnd_ready_indep", in_ready, r0);
      acc = in_valid & in_ready;
      tick();
      if (acc) begin
        cnt_in++;
        in_valid = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd_count", n_out - base, 1000);
    chk("rnd_ovf", ovf_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
